// File: rtl/bcd_display_pkg.sv
// Shared definitions for the three-digit multiplexed 7-segment scanner.
// Holds the segment patterns ({g,f,e,d,c,b,a}, active-high), the digit
// index encoding used by the scan counter, the scan state type, and a helper
// that turns a digit index into its one-hot enable.
package bcd_display_pkg;

    localparam logic [6:0] SEG_0    = 7'h3F;
    localparam logic [6:0] SEG_1    = 7'h06;
    localparam logic [6:0] SEG_2    = 7'h5B;
    localparam logic [6:0] SEG_3    = 7'h4F;
    localparam logic [6:0] SEG_4    = 7'h66;
    localparam logic [6:0] SEG_5    = 7'h6D;
    localparam logic [6:0] SEG_6    = 7'h7D;
    localparam logic [6:0] SEG_7    = 7'h07;
    localparam logic [6:0] SEG_8    = 7'h7F;
    localparam logic [6:0] SEG_9    = 7'h6F;
    localparam logic [6:0] SEG_DASH = 7'h40;
    localparam logic [6:0] SEG_OFF  = 7'h00;

    localparam logic [1:0] DIG_UNITS    = 2'd0;
    localparam logic [1:0] DIG_TENS     = 2'd1;
    localparam logic [1:0] DIG_HUNDREDS = 2'd2;

    typedef enum logic {
        ST_GAP = 1'b0,
        ST_ON  = 1'b1
    } scan_state_e;

    // One-hot digit enable for a scan index; the unused index maps to all-off.
    function automatic logic [2:0] dig_onehot(input logic [1:0] idx);
        logic [2:0] oh;
        case (idx)
            DIG_UNITS:    oh = 3'b001;
            DIG_TENS:     oh = 3'b010;
            DIG_HUNDREDS: oh = 3'b100;
            default:      oh = 3'b000;
        endcase
        return oh;
    endfunction

endpackage

// File: rtl/bcd_display_scan_seg7_decode.sv
// BCD to 7-segment decoder (combinational).
// Ports: bcd_i [3:0] digit value; seg_o [6:0] active-high {g,f,e,d,c,b,a}.
// Values 10..15 are not decimal digits and show a dash.
module seg7_decode
    import bcd_display_pkg::*;
(
    input  logic [3:0] bcd_i,
    output logic [6:0] seg_o
);

    // Pattern lookup for one digit.
    always_comb begin
        case (bcd_i)
            4'd0:    seg_o = SEG_0;
            4'd1:    seg_o = SEG_1;
            4'd2:    seg_o = SEG_2;
            4'd3:    seg_o = SEG_3;
            4'd4:    seg_o = SEG_4;
            4'd5:    seg_o = SEG_5;
            4'd6:    seg_o = SEG_6;
            4'd7:    seg_o = SEG_7;
            4'd8:    seg_o = SEG_8;
            4'd9:    seg_o = SEG_9;
            default: seg_o = SEG_DASH;
        endcase
    end

endmodule

// File: rtl/bcd_display_scan.sv
// Multiplexed three-digit 7-segment driver.
// Digits are captured into a pending register on load and promoted to the
// display register only at a slot start, so a digit never changes while lit.
// Each slot is DIGIT_CYCLES long: GAP_CYCLES dark, then the selected digit on.
// Ports:
//   clk, rst_n             clock, asynchronous active-low reset
//   hundreds[1:0], tens[3:0], units[3:0]  BCD digits, captured on load
//   load                   capture strobe
//   lz_blank               leading-zero blanking, sampled at slot start
//   seg[6:0]               {g,f,e,d,c,b,a}, registered, inverted if ACTIVE_LOW
//   dig_en[2:0]            one-hot digit enable (0 units, 1 tens, 2 hundreds)
//   shown                  one-cycle pulse when pending data reaches the display
module bcd_display_scan
    import bcd_display_pkg::*;
#(
    parameter int DIGIT_CYCLES = 4000,
    parameter int GAP_CYCLES   = 16,
    parameter bit ACTIVE_LOW   = 1'b0
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [1:0] hundreds,
    input  logic [3:0] tens,
    input  logic [3:0] units,
    input  logic       load,
    input  logic       lz_blank,
    output logic [6:0] seg,
    output logic [2:0] dig_en,
    output logic       shown
);

    localparam int              CNT_W    = (DIGIT_CYCLES > 1) ? $clog2(DIGIT_CYCLES) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DIGIT_CYCLES - 1);
    localparam logic [CNT_W-1:0] GAP_END  = CNT_W'(GAP_CYCLES);
    localparam logic [6:0]      SEG_IDLE = ACTIVE_LOW ? 7'h7F : 7'h00;
    localparam logic [2:0]      DIG_IDLE = ACTIVE_LOW ? 3'b111 : 3'b000;

    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [1:0]       idx_q, idx_d;
    scan_state_e      state_q, state_d;

    logic [1:0] pend_h_q, pend_h_d, disp_h_q, disp_h_d;
    logic [3:0] pend_t_q, pend_t_d, disp_t_q, disp_t_d;
    logic [3:0] pend_u_q, pend_u_d, disp_u_q, disp_u_d;
    logic       pend_valid_q, pend_valid_d, disp_valid_q, disp_valid_d;
    logic       lz_q, lz_d;

    logic       slot_start_s, slot_end_s, promote_s, blank_s, lit_s;
    logic [3:0] digit_s;
    logic [6:0] dec_s, seg_d;
    logic [2:0] dig_en_d;
    logic [6:0] seg_q;
    logic [2:0] dig_en_q;
    logic       shown_q;

    assign slot_start_s = (cnt_q == '0);
    assign slot_end_s   = (cnt_q == CNT_LAST);

    // Slot counter and digit index advance; index wraps after hundreds.
    always_comb begin
        cnt_d = cnt_q;
        idx_d = idx_q;
        if (slot_end_s) begin
            cnt_d = '0;
            if (idx_q >= DIG_HUNDREDS) begin
                idx_d = DIG_UNITS;
            end else begin
                idx_d = idx_q + 2'd1;
            end
        end else begin
            cnt_d = cnt_q + CNT_W'(1);
        end
    end

    // Next scan state follows the next counter value so state_q tracks cnt_q.
    always_comb begin
        if (cnt_d < GAP_END) begin
            state_d = ST_GAP;
        end else begin
            state_d = ST_ON;
        end
    end

    // Scan state register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_GAP;
        end else begin
            state_q <= state_d;
        end
    end

    // Pending/display data path: promotion only at slot start, with bypass of
    // a load arriving on that very cycle.
    always_comb begin
        pend_h_d     = pend_h_q;
        pend_t_d     = pend_t_q;
        pend_u_d     = pend_u_q;
        pend_valid_d = pend_valid_q;
        disp_h_d     = disp_h_q;
        disp_t_d     = disp_t_q;
        disp_u_d     = disp_u_q;
        disp_valid_d = disp_valid_q;
        lz_d         = lz_q;
        promote_s    = 1'b0;
        if (slot_start_s) begin
            lz_d = lz_blank;
            if (load) begin
                disp_h_d     = hundreds;
                disp_t_d     = tens;
                disp_u_d     = units;
                disp_valid_d = 1'b1;
                pend_valid_d = 1'b0;
                promote_s    = 1'b1;
            end else if (pend_valid_q) begin
                disp_h_d     = pend_h_q;
                disp_t_d     = pend_t_q;
                disp_u_d     = pend_u_q;
                disp_valid_d = 1'b1;
                pend_valid_d = 1'b0;
                promote_s    = 1'b1;
            end else begin
                promote_s    = 1'b0;
            end
        end else if (load) begin
            pend_h_d     = hundreds;
            pend_t_d     = tens;
            pend_u_d     = units;
            pend_valid_d = 1'b1;
        end else begin
            pend_valid_d = pend_valid_q;
        end
    end

    // Output decision: pick the scanned digit, apply blanking, form enables.
    always_comb begin
        digit_s = 4'd0;
        blank_s = 1'b1;
        case (idx_q)
            DIG_UNITS: begin
                digit_s = disp_u_q;
                blank_s = 1'b0;
            end
            DIG_TENS: begin
                digit_s = disp_t_q;
                blank_s = lz_q && (disp_h_q == 2'd0) && (disp_t_q == 4'd0);
            end
            DIG_HUNDREDS: begin
                digit_s = {2'b00, disp_h_q};
                blank_s = lz_q && (disp_h_q == 2'd0);
            end
            default: begin
                digit_s = 4'd0;
                blank_s = 1'b1;
            end
        endcase
        lit_s = (state_q == ST_ON) && disp_valid_q && !blank_s;
        if (lit_s) begin
            seg_d    = dec_s;
            dig_en_d = dig_onehot(idx_q);
        end else begin
            seg_d    = SEG_OFF;
            dig_en_d = 3'b000;
        end
    end

    seg7_decode u_decode (
        .bcd_i (digit_s),
        .seg_o (dec_s)
    );

    // Counter, data registers and output registers (polarity applied here).
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q        <= '0;
            idx_q        <= DIG_UNITS;
            pend_h_q     <= 2'd0;
            pend_t_q     <= 4'd0;
            pend_u_q     <= 4'd0;
            pend_valid_q <= 1'b0;
            disp_h_q     <= 2'd0;
            disp_t_q     <= 4'd0;
            disp_u_q     <= 4'd0;
            disp_valid_q <= 1'b0;
            lz_q         <= 1'b0;
            seg_q        <= SEG_IDLE;
            dig_en_q     <= DIG_IDLE;
            shown_q      <= 1'b0;
        end else begin
            cnt_q        <= cnt_d;
            idx_q        <= idx_d;
            pend_h_q     <= pend_h_d;
            pend_t_q     <= pend_t_d;
            pend_u_q     <= pend_u_d;
            pend_valid_q <= pend_valid_d;
            disp_h_q     <= disp_h_d;
            disp_t_q     <= disp_t_d;
            disp_u_q     <= disp_u_d;
            disp_valid_q <= disp_valid_d;
            lz_q         <= lz_d;
            seg_q        <= seg_d ^ {7{ACTIVE_LOW}};
            dig_en_q     <= dig_en_d ^ {3{ACTIVE_LOW}};
            shown_q      <= promote_s;
        end
    end

    assign seg    = seg_q;
    assign dig_en = dig_en_q;
    assign shown  = shown_q;

endmodule

// File: tb/tb_bcd_display_scan.sv
// Scoreboard bench: stimulus pushes the expected lit runs (enable, pattern,
// length) per instance; a monitor pops one entry each time a lit run ends.
// Instance 0 is active-high, instance 1 active-low, both on the same inputs.
module tb_bcd_display_scan;

    typedef struct {
        logic [2:0] dig;
        logic [6:0] seg;
        int         len;
    } exp_t;

    logic       clk;
    logic       rst_n;
    logic [1:0] hundreds;
    logic [3:0] tens;
    logic [3:0] units;
    logic       load;
    logic       lz_blank;
    logic [6:0] seg0, seg1;
    logic [2:0] dig0, dig1;
    logic       shown0, shown1;

    int   total = 0;
    int   bad   = 0;
    exp_t exp_q0[$];
    exp_t exp_q1[$];
    int   run_len[2];
    logic [2:0] cur_dig[2];
    logic [6:0] cur_seg[2];
    int   shown_cnt[2];

    bcd_display_scan #(.DIGIT_CYCLES(8), .GAP_CYCLES(2), .ACTIVE_LOW(1'b0)) u_dut_ah (
        .clk(clk), .rst_n(rst_n), .hundreds(hundreds), .tens(tens), .units(units),
        .load(load), .lz_blank(lz_blank), .seg(seg0), .dig_en(dig0), .shown(shown0)
    );

    bcd_display_scan #(.DIGIT_CYCLES(8), .GAP_CYCLES(2), .ACTIVE_LOW(1'b1)) u_dut_al (
        .clk(clk), .rst_n(rst_n), .hundreds(hundreds), .tens(tens), .units(units),
        .load(load), .lz_blank(lz_blank), .seg(seg1), .dig_en(dig1), .shown(shown1)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] want);
        total++;
        if (got !== want) begin
            bad++;
            $display("FAIL %s got=%h want=%h", name, got, want);
        end
    endtask

    task automatic expect_lit(input logic [2:0] d, input logic [6:0] s, input int len);
        exp_t e;
        e.dig = d;  e.seg = s;  e.len = len;
        exp_q0.push_back(e);
        e.dig = ~d; e.seg = ~s;
        exp_q1.push_back(e);
    endtask

    task automatic mon_one(input int i, input logic [6:0] s, input logic [2:0] d, input logic sh);
        logic [2:0] inact_d;
        logic [6:0] inact_s;
        exp_t e;
        inact_d = (i == 1) ? 3'b111 : 3'b000;
        inact_s = (i == 1) ? 7'h7F : 7'h00;
        if (sh) shown_cnt[i]++;
        if (d === inact_d) begin
            total++;
            if (s !== inact_s) begin
                bad++;
                $display("FAIL dark_seg inst=%0d got=%h want=%h", i, s, inact_s);
            end
            if (run_len[i] > 0) begin
                total++;
                if ((i == 0 && exp_q0.size() == 0) || (i == 1 && exp_q1.size() == 0)) begin
                    bad++;
                    $display("FAIL unexpected_lit inst=%0d got dig=%b seg=%h len=%0d want none",
                             i, cur_dig[i], cur_seg[i], run_len[i]);
                end else begin
                    if (i == 0) e = exp_q0.pop_front();
                    else        e = exp_q1.pop_front();
                    if (cur_dig[i] !== e.dig || cur_seg[i] !== e.seg || run_len[i] != e.len) begin
                        bad++;
                        $display("FAIL lit_run inst=%0d got dig=%b seg=%h len=%0d want dig=%b seg=%h len=%0d",
                                 i, cur_dig[i], cur_seg[i], run_len[i], e.dig, e.seg, e.len);
                    end
                end
            end
            run_len[i] = 0;
        end else begin
            if (run_len[i] == 0) begin
                cur_dig[i] = d;
                cur_seg[i] = s;
            end else begin
                total++;
                if (d !== cur_dig[i] || s !== cur_seg[i]) begin
                    bad++;
                    $display("FAIL steady inst=%0d got dig=%b seg=%h want dig=%b seg=%h",
                             i, d, s, cur_dig[i], cur_seg[i]);
                end
            end
            run_len[i]++;
        end
    endtask

    // Monitor: sample both instances just after each rising edge.
    always @(posedge clk) begin
        #1;
        mon_one(0, seg0, dig0, shown0);
        mon_one(1, seg1, dig1, shown1);
    end

    // Reset, then run ncyc cycles; cycle c is the cycle closed by the c-th
    // rising edge after release (cycle 0 is a slot start).
    task automatic run_scen(input int ncyc, input int lc0, input logic [9:0] d0,
                            input int lc1, input logic [9:0] d1, input logic lz,
                            input int rst_at, input int chk_cyc, input logic [2:0] chk_dig,
                            input int exp_shown);
        int base0, base1;
        @(negedge clk);
        rst_n = 1'b0; load = 1'b0; lz_blank = lz;
        @(negedge clk);
        rst_n = 1'b1;
        base0 = shown_cnt[0];
        base1 = shown_cnt[1];
        for (int c = 0; c < ncyc; c++) begin
            if (c == lc0) begin
                load = 1'b1; {hundreds, tens, units} = d0;
            end else if (c == lc1) begin
                load = 1'b1; {hundreds, tens, units} = d1;
            end else begin
                load = 1'b0;
            end
            @(posedge clk);
            @(negedge clk);
            if (c == chk_cyc - 1) begin
                check("pre_light_dark", {29'd0, dig0}, 32'd0);
            end
            if (c == chk_cyc) begin
                check("first_light_ah", {29'd0, dig0}, {29'd0, chk_dig});
                check("first_light_al", {29'd0, dig1}, {29'd0, ~chk_dig});
            end
            if (c == rst_at) begin
                rst_n = 1'b0;
                load  = 1'b0;
                #1;
                check("rst_dig_ah", {29'd0, dig0}, 32'd0);
                check("rst_seg_ah", {25'd0, seg0}, 32'd0);
                check("rst_dig_al", {29'd0, dig1}, 32'h7);
                check("rst_seg_al", {25'd0, seg1}, 32'h7F);
            end
            if (c == rst_at + 2) begin
                rst_n = 1'b1;
            end
        end
        load = 1'b0;
        check("queue_drained_ah", exp_q0.size(), 32'd0);
        check("queue_drained_al", exp_q1.size(), 32'd0);
        check("shown_ah", shown_cnt[0] - base0, exp_shown);
        check("shown_al", shown_cnt[1] - base1, exp_shown);
    endtask

    initial begin
        rst_n = 1'b0; load = 1'b0; lz_blank = 1'b0;
        hundreds = 2'd0; tens = 4'd0; units = 4'd0;
        for (int i = 0; i < 2; i++) begin
            run_len[i] = 0; shown_cnt[i] = 0; cur_dig[i] = 3'd0; cur_seg[i] = 7'd0;
        end
        repeat (3) @(negedge clk);
        check("reset_seg_ah",   {25'd0, seg0},   32'h00);
        check("reset_dig_ah",   {29'd0, dig0},   32'h0);
        check("reset_shown_ah", {31'd0, shown0}, 32'd0);
        check("reset_seg_al",   {25'd0, seg1},   32'h7F);
        check("reset_dig_al",   {29'd0, dig1},   32'h7);
        check("reset_shown_al", {31'd0, shown1}, 32'd0);

        // Reset, no load: dark for 100 cycles.
        run_scen(100, -1, 10'd0, -1, 10'd0, 1'b0, -10, -10, 3'b000, 0);

        // Load and scan 2/5/5, bypass load on the first slot start.
        expect_lit(3'b001, 7'h6D, 6);
        expect_lit(3'b010, 7'h6D, 6);
        expect_lit(3'b100, 7'h5B, 6);
        run_scen(25, 0, {2'd2, 4'd5, 4'd5}, -1, 10'd0, 1'b0, -10, 2, 3'b001, 1);

        // Leading-zero blanking 0/0/7: only units lit.
        expect_lit(3'b001, 7'h07, 6);
        run_scen(25, 0, {2'd0, 4'd0, 4'd7}, -1, 10'd0, 1'b1, -10, -10, 3'b000, 1);

        // Leading-zero blanking 0/3/0: units and tens lit.
        expect_lit(3'b001, 7'h3F, 6);
        expect_lit(3'b010, 7'h4F, 6);
        run_scen(25, 0, {2'd0, 4'd3, 4'd0}, -1, 10'd0, 1'b1, -10, -10, 3'b000, 1);

        // Invalid units digit 12 shows a dash, no blanking.
        expect_lit(3'b001, 7'h40, 6);
        expect_lit(3'b010, 7'h3F, 6);
        expect_lit(3'b100, 7'h3F, 6);
        run_scen(25, 0, {2'd0, 4'd0, 4'd12}, -1, 10'd0, 1'b0, -10, -10, 3'b000, 1);

        // Last wins: u=1 then u=4 inside slot 0, promoted at slot 1 (tens, blank),
        // so units first lights in slot 3.
        expect_lit(3'b001, 7'h66, 6);
        run_scen(33, 3, {2'd0, 4'd0, 4'd1}, 5, {2'd0, 4'd0, 4'd4}, 1'b1, -10, -10, 3'b000, 1);

        // Load on slot-2 start: hundreds lit GAP+1 cycles later, then units.
        expect_lit(3'b100, 7'h06, 6);
        expect_lit(3'b001, 7'h4F, 6);
        run_scen(33, 16, {2'd1, 4'd2, 4'd3}, -1, 10'd0, 1'b0, -10, 18, 3'b100, 1);

        // Mid-ON reset: units run cut to 3 cycles, then dark with no new load.
        expect_lit(3'b001, 7'h6D, 3);
        run_scen(32, 0, {2'd2, 4'd5, 4'd5}, -1, 10'd0, 1'b0, 4, -10, 3'b000, 1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
